unary_stream_decoder: RTL and testbench
=======================================

Name: unary_stream_decoder

Overview:
- Downstream stage of the unary adder. Consumes the serial thermometer-coded sum on the adder's dout and its carry/overflow flag C once the adder enters write mode (read_or_write=1).
- Counts the ones in a fixed-length window, checks the stream is a legal thermometer code, and presents the binary sum with a valid/ready handshake for binary-domain logic and for self-checking benches.

Parameters:
MAX_LEN, 15, sample-window length in cycles; also the largest legal unary value.
CW, 4, count width; must satisfy 2^CW > MAX_LEN.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse, coincident with the first stream bit; taken by the controller from the adder's read_or_write rising edge.
din  input  1  serial unary stream, connected to the adder's dout.
ovf_in  input  1  adder overflow flag, connected to the adder's C.
out_ready  input  1  consumer accepts the result.
out_valid  output  1  result held and valid.
count  output  CW  number of ones seen in the window, binary.
ovf  output  1  ovf_in was high on at least one window cycle.
err  output  1  illegal code: a 1 sampled after a 0 in the same window.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE.
  - out_valid, count, ovf, err, busy all go to 0.
  - Internal window counter and seen-zero flag clear.
  - Reset applies at any time, including mid-window or in DONE; any partial result is discarded.
- States: IDLE, COUNT, DONE.
- IDLE:
  - start=1 is the first sample edge: din is bit 0 and ovf_in is sampled too.
  - count loads din, ovf loads ovf_in, err loads 0, seen-zero loads ~din, window counter loads 1.
  - Go to COUNT. If MAX_LEN==1, go straight to DONE.
- COUNT: one sample per cycle.
  - count increments on din=1; it saturates at MAX_LEN and never wraps.
  - ovf |= ovf_in.
  - din=1 with seen-zero=1 sets err (sticky).
  - din=0 sets seen-zero.
  - When the window counter reaches MAX_LEN samples, go to DONE.
- DONE:
  - out_valid=1 from the cycle after the last sample. Latency is MAX_LEN cycles from the start edge to out_valid high.
  - count, ovf and err hold stable while out_valid=1 and out_ready=0.
  - Transfer happens on an edge with out_valid=1 and out_ready=1. Next state is IDLE and out_valid drops the following cycle.
- start is honoured only in IDLE; it is ignored in COUNT and DONE, including the transfer cycle itself.
- count, ovf and err keep their last values in IDLE until the next accepted start.
- din and ovf_in are ignored outside the window.
- Minimum gap between accepted starts is MAX_LEN+1 cycles.

Optional Feature:
- Macro: UNARY_DEC_EARLY_END_EN.
- Defined:
  - In COUNT, the first din=0 sample ends the window; DONE follows the next cycle.
  - A stream with no zero still ends after MAX_LEN samples.
  - err is tied to 0 because bubble detection is unavailable.
  - Latency is (count+1) cycles, or MAX_LEN if the stream is all ones.
- Undefined: fixed MAX_LEN window and bubble checking as specified above.

Test Plan:
- Reset check: rst_n low for 2 cycles -> out_valid=0, count=0, ovf=0, err=0, busy=0.
- Normal value: start with din = 7 ones then 8 zeros, ovf_in=0 -> out_valid on cycle 15 after start, count=7, err=0, ovf=0. Under UNARY_DEC_EARLY_END_EN: out_valid on cycle 8.
- Full scale with overflow: din = 15 ones, ovf_in pulses high on window cycle 14 -> count=15, ovf=1, err=0.
- Bubble: din = 1,1,0,1, then zeros -> count=3, err=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, start pulsed during that time -> outputs stable, start ignored. Then out_ready=1 -> IDLE next cycle, busy=0.
- Reset mid-window: rst_n low at window cycle 6 -> everything clears. A fresh start with 4 ones -> count=4, err=0.

Source files
------------

// File: rtl/unary_stream_decoder.sv
// Serial thermometer-code decoder: counts ones over a sample window, flags overflow and bubbles,
// and hands the binary sum out over a valid/ready port. Define UNARY_DEC_EARLY_END_EN to end on the first zero.
module unary_stream_decoder #(
  parameter int MAX_LEN = 15,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          din,
  input  logic          ovf_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          err,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

`ifdef UNARY_DEC_EARLY_END_EN
  localparam bit EARLY_END = 1'b1;
`else
  localparam bit EARLY_END = 1'b0;
`endif

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] count_q,     count_d;
  logic [CW-1:0] win_cnt_q,   win_cnt_d;
  logic          ovf_q,       ovf_d;
  logic          err_q,       err_d;
  logic          seen_zero_q, seen_zero_d;

  always_comb begin
    // NOTE: every target gets a hold default first, so no path through the case leaves a latch.
    state_d     = state_q;
    count_d     = count_q;
    win_cnt_d   = win_cnt_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    seen_zero_d = seen_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d     = CW'(din);
          ovf_d       = ovf_in;
          err_d       = 1'b0;
          seen_zero_d = ~din;
          win_cnt_d   = CW'(1);
          if (MAX_LEN == 1 || (EARLY_END && !din)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COUNT;
          end
        end
      end

      S_COUNT: begin
        // Saturate rather than wrap so a malformed stream cannot alias to a small value.
        if (din && count_q != MAX_CNT) begin
          count_d = count_q + CW'(1);
        end
        ovf_d = ovf_q | ovf_in;
        if (!EARLY_END && din && seen_zero_q) begin
          err_d = 1'b1;
        end
        if (!din) begin
          seen_zero_d = 1'b1;
        end
        win_cnt_d = win_cnt_q + CW'(1);
        if (win_cnt_d == MAX_CNT || (EARLY_END && !din)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      win_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      seen_zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      count_q     <= count_d;
      win_cnt_q   <= win_cnt_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      seen_zero_q <= seen_zero_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign err       = EARLY_END ? 1'b0 : err_q;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder in its default (fixed window, bubble-checking) build.
// Expected values are hand-derived from the stream patterns fed in.
module tb_unary_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       din;
  logic       ovf_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] count;
  logic       ovf;
  logic       err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  unary_stream_decoder #(.MAX_LEN(15), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .ovf_in    (ovf_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .count     (count),
    .ovf       (ovf),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feeds one 15-sample window, bit 0 first, with start on the first sample.
  task automatic feed(input string tag, input logic [14:0] bits, input logic [14:0] ovfs);
    for (int i = 0; i < 15; i++) begin
      start  = (i == 0);
      din    = bits[i];
      ovf_in = ovfs[i];
      step();
      if (i == 13) check({tag, "_valid_early"}, out_valid, 1'b0);
    end
    start  = 1'b0;
    din    = 1'b0;
    ovf_in = 1'b0;
    check({tag, "_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    din       = 1'b0;
    ovf_in    = 1'b0;
    out_ready = 1'b1;

    step();
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_ovf",   ovf,   1'b0);
    check("rst_err",   err,   1'b0);
    check("rst_busy",  busy,  1'b0);
    rst_n = 1'b1;
    step();

    // 7 ones then 8 zeros; start pulsed again on the transfer edge must be ignored.
    feed("norm", 15'h007F, 15'h0000);
    check("norm_count", count, 4'd7);
    check("norm_ovf",   ovf,   1'b0);
    check("norm_err",   err,   1'b0);
    check("norm_busy",  busy,  1'b1);
    start = 1'b1;
    din   = 1'b1;
    step();
    start = 1'b0;
    din   = 1'b0;
    check("xfer_valid", out_valid, 1'b0);
    check("xfer_busy",  busy,      1'b0);
    check("idle_count", count,     4'd7);

    // Full scale, ovf_in high on the 14th window cycle only.
    feed("full", 15'h7FFF, 15'h2000);
    check("full_count", count, 4'd15);
    check("full_ovf",   ovf,   1'b1);
    check("full_err",   err,   1'b0);
    step();
    check("full_done_busy", busy, 1'b0);

    // Bubble 1,1,0,1 under backpressure.
    out_ready = 1'b0;
    feed("bub", 15'h000B, 15'h0000);
    check("bub_count", count, 4'd3);
    check("bub_err",   err,   1'b1);
    check("bub_ovf",   ovf,   1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      din   = 1'b1;
      step();
    end
    start = 1'b0;
    din   = 1'b0;
    check("bp_valid", out_valid, 1'b1);
    check("bp_count", count,     4'd3);
    check("bp_err",   err,       1'b1);
    check("bp_busy",  busy,      1'b1);
    out_ready = 1'b1;
    step();
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_busy",  busy,      1'b0);
    step();
    check("bp_idle_busy", busy, 1'b0);

    // Reset in the middle of a window, then a fresh 4-ones window.
    for (int i = 0; i < 6; i++) begin
      start = (i == 0);
      din   = 1'b1;
      step();
    end
    start = 1'b0;
    check("mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", out_valid, 1'b0);
    check("mid_count", count,     4'd0);
    check("mid_ovf",   ovf,       1'b0);
    check("mid_err",   err,       1'b0);
    check("mid_busy",  busy,      1'b0);
    step();
    rst_n = 1'b1;
    step();
    feed("post", 15'h000F, 15'h0000);
    check("post_count", count, 4'd4);
    check("post_err",   err,   1'b0);
    check("post_ovf",   ovf,   1'b0);
    step();
    check("post_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
